log_event_tx: RTL and testbench
===============================

# log_event_tx

RTL-side log record transmitter: captures fire-and-forget log events raised by design logic, filters them by severity, buffers them in a small FIFO and serializes each into a fixed 7-byte framed record on a byte stream read by the testbench logger proxy. It sits inside the DUT boundary and drives the receiving side of the logger interface. It also keeps saturating error/drop statistics and a sticky fatal flag.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ev_valid  in  1  log event strobe; one event per cycle; no backpressure
- ev_sev  in  2  severity: 0 INFO, 1 WARN, 2 ERROR, 3 FATAL
- ev_id  in  8  message id
- ev_data  in  32  message payload
- thresh  in  2  minimum severity enqueued; sampled on ev_valid cycle
- tx_valid  out  1  byte valid
- tx_ready  in  1  consumer ready
- tx_byte  out  8  record byte
- tx_last  out  1  high on byte 6 of a record
- drop_cnt  out  16  events lost to full FIFO, saturating
- err_cnt  out  16  events seen with sev >= ERROR, saturating
- fatal  out  1  sticky; set by any FATAL event

## Operation
- Filter: an event with ev_sev < thresh is discarded silently (not counted as a drop). FATAL (3) always passes, regardless of thresh.
- Enqueue: a passing event is written to the FIFO if it is not full. If the FIFO is full, the event is lost and drop_cnt increments.
- Simultaneous pop and write on a full FIFO: the pop frees the slot, so the write succeeds and there is no drop.
- Sequence: a 6-bit seq counter increments on every successful enqueue and wraps 63->0. The value at enqueue time is stored with the entry, so gaps in seq reveal drops to the consumer.
- Record bytes, in order:
  - byte 0: 0xA5
  - byte 1: {sev[1:0], seq[5:0]}
  - byte 2: id
  - bytes 3-6: data[31:24], data[23:16], data[15:8], data[7:0]
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the output register, set idx=0, go to SEND.
  - SEND: drive byte idx. On a handshake (tx_valid && tx_ready), idx++. On the handshake of idx=6:
    - FIFO non-empty: pop the next entry and stay in SEND with idx=0, with no bubble.
    - FIFO empty: go to IDLE.
- err_cnt counts every ev_valid with ev_sev >= 2, whether filtered or dropped. It saturates at 0xFFFF, and drop_cnt saturates the same way.
- fatal is set the cycle after any ev_valid with ev_sev == 3. It is cleared only by reset.

## Timing
- Reset (async assert, sync release) returns the block to:
  - tx_valid=0, tx_byte=0, tx_last=0
  - drop_cnt=0, err_cnt=0, fatal=0
  - seq=0, FIFO empty, FSM in IDLE
- Reset asserted mid-record abandons the record immediately. No partial record resumes after release.
- Latency: an event on cycle N into an empty FIFO with the FSM in IDLE gives tx_valid=1 with byte 0 on cycle N+2.
- Stream rules:
  - tx_byte and tx_last are held stable while tx_valid && !tx_ready.
  - tx_valid never drops mid-record.
  - tx_valid never depends combinationally on tx_ready.
- Throughput: with tx_ready held high, 7 cycles per record, back-to-back. Sustained event rates above 1 per 7 cycles eventually overflow the FIFO.
- Counters and fatal are registered and update on the cycle after the event.

## Test plan
- Single event: thresh=0, event sev=1, id=0x12, data=0xDEADBEEF, tx_ready=1.
  - Expect bytes A5,40,12,DE,AD,BE,EF on cycles N+2..N+8.
  - tx_last on the 7th byte only; then IDLE.
- Filter: thresh=2.
  - Events sev 0,1 emit nothing and leave drop_cnt=0.
  - A sev=2 event emits a record with byte 1 = 0x80 (seq 0); err_cnt=1.
  - A sev=3 event with thresh=3 emits a record; fatal=1 and stays 1 until rst_n.
- Overflow: DEPTH=4, tx_ready=0, 6 consecutive INFO events.
  - First record loads (idx 0) and 4 are queued, so drop_cnt=1.
  - Releasing tx_ready yields 5 records with seq 0..4, back-to-back, no bubbles.
- Full with simultaneous pop: event arrives on the last-byte handshake cycle while the FIFO is full.
  - drop_cnt is unchanged and the event appears as a later record.
- Backpressure: toggle tx_ready randomly every cycle.
  - tx_byte/tx_last stay stable whenever stalled, and byte order is intact.
- Saturation and wrap:
  - Force err_cnt near 0xFFFF and send 3 ERROR events: err_cnt stays 0xFFFF.
  - Send 65 events: byte 1 of record 64 carries seq=0.
  - Assert rst_n low mid-record: all outputs and counters read zero on the next cycle.

Source files
------------

// File: rtl/log_event_tx_if.sv
// Log event / record stream bundle between the event-raising logic, the
// log transmitter and the byte-stream consumer.
interface log_event_tx_if;
    logic        ev_valid;
    logic [1:0]  ev_sev;
    logic [7:0]  ev_id;
    logic [31:0] ev_data;
    logic [1:0]  thresh;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic        tx_last;

    modport master (
        input  ev_valid, ev_sev, ev_id, ev_data, thresh, tx_ready,
        output tx_valid, tx_byte, tx_last
    );

    modport slave (
        output ev_valid, ev_sev, ev_id, ev_data, thresh, tx_ready,
        input  tx_valid, tx_byte, tx_last
    );
endinterface

// File: rtl/log_event_tx.sv
// Log event transmitter: severity filter, small FIFO with drop/error statistics,
// and a 7-byte framed record serializer on a ready/valid byte stream.
module log_event_tx #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    log_event_tx_if.master bus,
    output logic [15:0]    drop_cnt,
    output logic [15:0]    err_cnt,
    output logic           fatal
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef struct packed {
        logic [1:0]  sev;
        logic [5:0]  seq;
        logic [7:0]  id;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {IDLE, SEND} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    entry_t        mem_p0 [DEPTH];
    logic [AW-1:0] wr_ptr_p0;
    logic [AW-1:0] rd_ptr_p0;
    logic [AW:0]   count_p0;
    logic [5:0]    seq_p0;
    logic          full_p0;
    logic          empty_p0;
    logic          pass_p0;
    logic          push_p0;
    logic          drop_p0;
    logic          pop_p0;
    logic          is_err;
    logic          is_fatal;

    state_t        state_q;
    state_t        state_d;
    logic [2:0]    idx_p1;
    logic [2:0]    idx_d;
    entry_t        rec_p1;
    logic          vld_p1;
    logic          hs_p1;
    logic [7:0]    byte_p1;

    // ---- stage 0: filter, enqueue, statistics ----
    assign full_p0  = (count_p0 == (AW+1)'(DEPTH));
    assign empty_p0 = (count_p0 == '0);
    assign pass_p0  = bus.ev_valid && ((bus.ev_sev >= bus.thresh) || (bus.ev_sev == 2'd3));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_p0  = pass_p0 && (!full_p0 || pop_p0);
    assign drop_p0  = pass_p0 && full_p0 && !pop_p0;
    assign is_err   = bus.ev_valid && bus.ev_sev[1];
    assign is_fatal = bus.ev_valid && (bus.ev_sev == 2'd3);

    always_ff @(posedge clk) begin
        if (push_p0) begin
            mem_p0[wr_ptr_p0] <= '{sev: bus.ev_sev, seq: seq_p0, id: bus.ev_id, data: bus.ev_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            count_p0  <= '0;
            seq_p0    <= '0;
        end else begin
            if (push_p0) begin
                wr_ptr_p0 <= wr_ptr_p0 + AW'(1);
                seq_p0    <= seq_p0 + 6'd1;
            end
            if (pop_p0) begin
                rd_ptr_p0 <= rd_ptr_p0 + AW'(1);
            end
            unique case ({push_p0, pop_p0})
                2'b10:   count_p0 <= count_p0 + (AW+1)'(1);
                2'b01:   count_p0 <= count_p0 - (AW+1)'(1);
                default: count_p0 <= count_p0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
            fatal    <= 1'b0;
        end else begin
            if (drop_p0) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            if (is_err) begin
                err_cnt <= sat_inc(err_cnt);
            end
            if (is_fatal) begin
                fatal <= 1'b1;
            end
        end
    end

    // ---- stage 1: record serializer ----
    assign vld_p1 = (state_q == SEND);
    assign hs_p1  = vld_p1 && bus.tx_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_p1;
        pop_p0  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty_p0) begin
                    pop_p0  = 1'b1;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs_p1) begin
                    if (idx_p1 == LAST_IDX) begin
                        // Chain straight into the next record without a bubble.
                        idx_d = 3'd0;
                        if (!empty_p0) begin
                            pop_p0 = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_p1 + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_p1  <= '0;
        end else begin
            state_q <= state_d;
            idx_p1  <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pop_p0) begin
            rec_p1 <= mem_p0[rd_ptr_p0];
        end
    end

    // Byte mux is gated by valid so the stream reads zero while idle or in reset.
    always_comb begin
        byte_p1 = 8'h00;
        if (vld_p1) begin
            unique case (idx_p1)
                3'd0:    byte_p1 = SYNC;
                3'd1:    byte_p1 = {rec_p1.sev, rec_p1.seq};
                3'd2:    byte_p1 = rec_p1.id;
                3'd3:    byte_p1 = rec_p1.data[31:24];
                3'd4:    byte_p1 = rec_p1.data[23:16];
                3'd5:    byte_p1 = rec_p1.data[15:8];
                3'd6:    byte_p1 = rec_p1.data[7:0];
                default: byte_p1 = 8'h00;
            endcase
        end
    end

    assign bus.tx_valid = vld_p1;
    assign bus.tx_byte  = byte_p1;
    assign bus.tx_last  = vld_p1 && (idx_p1 == LAST_IDX);
endmodule

// File: tb/tb_log_event_tx.sv
// Bench for log_event_tx: directed event vectors feed a byte scoreboard that a
// separate stream monitor drains and compares.
module tb_log_event_tx;
    logic        clk;
    logic        rst_n;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;
    logic        fatal;

    int n_vec  = 0;
    int n_miss = 0;

    logic [8:0] exp_q [$];
    logic [8:0] exp_e;
    logic [8:0] prev_bl;
    logic       prev_stall;
    logic       in_rec;
    logic       rand_rdy;

    log_event_tx_if bus();

    log_event_tx #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .drop_cnt (drop_cnt),
        .err_cnt  (err_cnt),
        .fatal    (fatal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [1:0] sev, input logic [5:0] seq,
                            input logic [7:0] id, input logic [31:0] data);
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, sev, seq});
        exp_q.push_back({1'b0, id});
        exp_q.push_back({1'b0, data[31:24]});
        exp_q.push_back({1'b0, data[23:16]});
        exp_q.push_back({1'b0, data[15:8]});
        exp_q.push_back({1'b1, data[7:0]});
    endtask

    task automatic send(input logic [1:0] sev, input logic [7:0] id, input logic [31:0] data);
        bus.ev_valid = 1'b1;
        bus.ev_sev   = sev;
        bus.ev_id    = id;
        bus.ev_data  = data;
        tick();
        bus.ev_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.tx_valid) && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        if (n >= budget) begin
            n_miss++;
            $display("FAIL drain_timeout: %0d bytes pending, expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Stream monitor: stall stability, no mid-record valid drop, scoreboard compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            in_rec     = 1'b0;
        end else begin
            if (prev_stall || in_rec) begin
                check("valid_held", {31'd0, bus.tx_valid}, 32'd1);
            end
            if (prev_stall) begin
                check("stall_stable", {23'd0, bus.tx_last, bus.tx_byte}, {23'd0, prev_bl});
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_byte: got %0h expected no output", {bus.tx_last, bus.tx_byte});
                end else begin
                    exp_e = exp_q.pop_front();
                    check("rec_byte", {23'd0, bus.tx_last, bus.tx_byte}, {23'd0, exp_e});
                end
                in_rec = !bus.tx_last;
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_bl    = {bus.tx_last, bus.tx_byte};
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 bus.tx_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        rst_n        = 1'b0;
        rand_rdy     = 1'b0;
        prev_stall   = 1'b0;
        in_rec       = 1'b0;
        prev_bl      = '0;
        bus.ev_valid = 1'b0;
        bus.ev_sev   = '0;
        bus.ev_id    = '0;
        bus.ev_data  = '0;
        bus.thresh   = '0;
        bus.tx_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_tx_byte", {24'd0, bus.tx_byte}, 32'd0);
        check("rst_tx_last", {31'd0, bus.tx_last}, 32'd0);
        check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("rst_fatal", {31'd0, fatal}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single event: latency N+2, seven bytes, then idle.
        push_rec(2'd1, 6'd0, 8'h12, 32'hDEADBEEF);
        send(2'd1, 8'h12, 32'hDEADBEEF);
        @(negedge clk);
        check("lat_n1_valid", {31'd0, bus.tx_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("lat_n2_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("lat_n2_byte", {24'd0, bus.tx_byte}, 32'hA5);
        repeat (7) @(negedge clk);
        check("single_idle", {31'd0, bus.tx_valid}, 32'd0);
        check("single_err", {16'd0, err_cnt}, 32'd0);
        drain(50);

        // Filter and fatal.
        do_reset();
        bus.thresh = 2'd2;
        send(2'd0, 8'h01, 32'h0);
        send(2'd1, 8'h02, 32'h0);
        repeat (4) tick();
        check("filt_no_out", {31'd0, bus.tx_valid}, 32'd0);
        check("filt_drop", {16'd0, drop_cnt}, 32'd0);
        check("filt_err0", {16'd0, err_cnt}, 32'd0);
        push_rec(2'd2, 6'd0, 8'h33, 32'h01020304);
        send(2'd2, 8'h33, 32'h01020304);
        check("filt_err1", {16'd0, err_cnt}, 32'd1);
        drain(50);
        check("pre_fatal", {31'd0, fatal}, 32'd0);
        bus.thresh = 2'd3;
        push_rec(2'd3, 6'd1, 8'h44, 32'hCAFEF00D);
        send(2'd3, 8'h44, 32'hCAFEF00D);
        check("fatal_set", {31'd0, fatal}, 32'd1);
        check("fatal_err", {16'd0, err_cnt}, 32'd2);
        drain(50);
        bus.thresh = 2'd0;
        push_rec(2'd0, 6'd2, 8'h45, 32'h00000045);
        send(2'd0, 8'h45, 32'h00000045);
        drain(50);
        check("fatal_sticky", {31'd0, fatal}, 32'd1);

        // Overflow with the consumer stalled, then a back-to-back burst.
        do_reset();
        check("fatal_cleared", {31'd0, fatal}, 32'd0);
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) push_rec(2'd0, 6'(i), 8'(8'h50 + i), 32'(32'h11111111 * i));
            send(2'd0, 8'(8'h50 + i), 32'(32'h11111111 * i));
        end
        @(negedge clk);
        check("ovf_drop", {16'd0, drop_cnt}, 32'd1);
        check("ovf_stall_byte", {24'd0, bus.tx_byte}, 32'hA5);
        tick();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            check("burst_no_bubble", {31'd0, bus.tx_valid}, 32'd1);
        end
        @(negedge clk);
        check("burst_end_idle", {31'd0, bus.tx_valid}, 32'd0);
        check("burst_drop", {16'd0, drop_cnt}, 32'd1);
        drain(50);

        // Full FIFO with a pop on the same cycle as the write.
        do_reset();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_rec(2'd1, 6'(i), 8'(8'h60 + i), 32'(32'h0F0F0000 + i));
            send(2'd1, 8'(8'h60 + i), 32'(32'h0F0F0000 + i));
        end
        tick();
        bus.tx_ready = 1'b1;
        repeat (6) tick();
        push_rec(2'd1, 6'd5, 8'h66, 32'h5A5A5A5A);
        send(2'd1, 8'h66, 32'h5A5A5A5A);
        @(negedge clk);
        check("simul_pop_drop", {16'd0, drop_cnt}, 32'd0);
        drain(100);

        // Random backpressure on the consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_rec(2'd1, 6'(6 + i), 8'(8'h70 + i), 32'(32'h89ABCDEF ^ i));
            send(2'd1, 8'(8'h70 + i), 32'(32'h89ABCDEF ^ i));
        end
        drain(2000);
        rand_rdy = 1'b0;
        tick();
        bus.tx_ready = 1'b1;
        check("bp_drop", {16'd0, drop_cnt}, 32'd0);

        // Sequence wrap: record 64 carries seq 0.
        do_reset();
        for (int i = 0; i < 65; i++) begin
            push_rec(2'd1, 6'(i), 8'(i), 32'(32'hA0000000 | i));
            send(2'd1, 8'(i), 32'(32'hA0000000 | i));
            repeat (7) tick();
        end
        drain(50);

        // err_cnt saturation with every event filtered.
        bus.thresh   = 2'd3;
        bus.ev_sev   = 2'd2;
        bus.ev_valid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("err_near_sat", {16'd0, err_cnt}, 32'h0000FFFE);
        tick();
        check("err_sat", {16'd0, err_cnt}, 32'h0000FFFF);
        repeat (3) tick();
        check("err_sat_hold", {16'd0, err_cnt}, 32'h0000FFFF);
        bus.ev_valid = 1'b0;
        check("sat_no_out", {31'd0, bus.tx_valid}, 32'd0);

        // Reset mid-record.
        bus.thresh = 2'd0;
        push_rec(2'd3, 6'd1, 8'h77, 32'h13579BDF);
        send(2'd3, 8'h77, 32'h13579BDF);
        repeat (4) tick();
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("mid_rst_byte", {24'd0, bus.tx_byte}, 32'd0);
        check("mid_rst_last", {31'd0, bus.tx_last}, 32'd0);
        check("mid_rst_drop", {16'd0, drop_cnt}, 32'd0);
        check("mid_rst_err", {16'd0, err_cnt}, 32'd0);
        check("mid_rst_fatal", {31'd0, fatal}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_resume", {31'd0, bus.tx_valid}, 32'd0);
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
